// File: rtl/moldudp64_msg_parser.sv
// moldudp64_msg_parser
// Parses a MoldUDP64 UDP payload, delivered as a byte stream with packet
// boundaries. It captures the 20-byte downstream header and splits the
// message block into individually delimited messages on a flow-controlled
// byte stream. It also tracks message sequence numbers and flags sequence
// gaps and malformed packets.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tready  payload byte input, s_tlast = last payload byte
//   m_tdata/m_tvalid/m_tready  message byte output (combinational from s_*)
//   m_tfirst/m_tlast           first / last byte of a message
//   m_msg_seq, m_msg_len       sequence number and declared length of message
//   session, pkt_seq,
//   pkt_msg_cnt                fields of the last complete header
//   hdr_valid, heartbeat,
//   end_session, seq_gap       header status pulses
//   err_len, err_trunc,
//   err_extra                  error pulses
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_HDR   | collecting the 20 header bytes
// ST_LEN   | collecting the 2-byte big-endian message length
// ST_DATA  | passing message bytes through to the output stream
// ST_DRAIN | discarding the rest of a bad / over-long packet until s_tlast
module moldudp64_msg_parser #(
    parameter int unsigned MAX_MSG_LEN  = 1024,
    parameter bit          SEQ_CHECK_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic         s_tlast,
    output logic [7:0]   m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic         m_tfirst,
    output logic         m_tlast,
    output logic [63:0]  m_msg_seq,
    output logic [15:0]  m_msg_len,
    output logic [79:0]  session,
    output logic [63:0]  pkt_seq,
    output logic [15:0]  pkt_msg_cnt,
    output logic         hdr_valid,
    output logic         heartbeat,
    output logic         end_session,
    output logic         seq_gap,
    output logic         err_len,
    output logic         err_trunc,
    output logic         err_extra
);

    localparam logic [1:0] ST_HDR   = 2'd0;
    localparam logic [1:0] ST_LEN   = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]   state;
    logic         run;
    logic [4:0]   hdr_idx;
    logic [151:0] hdr_sr;
    logic         len_phase;
    logic [7:0]   len_hi;
    logic [15:0]  msgs_rem;
    logic [15:0]  bytes_rem;
    logic [63:0]  exp_seq;
    logic         exp_valid;

    logic         accept;
    logic         in_data;
    logic [159:0] hdr_full;
    logic [63:0]  hdr_seq;
    logic [15:0]  hdr_cnt;
    logic [15:0]  len_full;
    logic         len_too_big;

    // run holds s_tready low while reset is asserted, so every output reads 0.
    assign in_data  = (state == ST_DATA);
    assign s_tready = run & (in_data ? m_tready : 1'b1);
    assign accept   = s_tvalid & s_tready;

    assign hdr_full    = {hdr_sr, s_tdata};
    assign hdr_seq     = hdr_full[79:16];
    assign hdr_cnt     = hdr_full[15:0];
    assign len_full    = {len_hi, s_tdata};
    assign len_too_big = ({16'd0, len_full} > MAX_MSG_LEN);

    assign m_tdata  = in_data ? s_tdata : 8'd0;
    assign m_tvalid = in_data & s_tvalid;
    assign m_tfirst = in_data & (bytes_rem == m_msg_len);
    assign m_tlast  = in_data & ((bytes_rem == 16'd1) | s_tlast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_HDR;
            run         <= 1'b0;
            hdr_idx     <= '0;
            hdr_sr      <= '0;
            len_phase   <= 1'b0;
            len_hi      <= '0;
            msgs_rem    <= '0;
            bytes_rem   <= '0;
            exp_seq     <= '0;
            exp_valid   <= 1'b0;
            m_msg_seq   <= '0;
            m_msg_len   <= '0;
            session     <= '0;
            pkt_seq     <= '0;
            pkt_msg_cnt <= '0;
            hdr_valid   <= 1'b0;
            heartbeat   <= 1'b0;
            end_session <= 1'b0;
            seq_gap     <= 1'b0;
            err_len     <= 1'b0;
            err_trunc   <= 1'b0;
            err_extra   <= 1'b0;
        end else begin
            run         <= 1'b1;
            hdr_valid   <= 1'b0;
            heartbeat   <= 1'b0;
            end_session <= 1'b0;
            seq_gap     <= 1'b0;
            err_len     <= 1'b0;
            err_trunc   <= 1'b0;
            err_extra   <= 1'b0;
            if (accept) begin
                case (state)
                    ST_HDR: begin
                        hdr_sr <= hdr_full[151:0];
                        if (hdr_idx != 5'd19) begin
                            if (s_tlast) begin
                                err_trunc <= 1'b1;
                                hdr_idx   <= '0;
                            end else begin
                                hdr_idx <= hdr_idx + 5'd1;
                            end
                        end else begin
                            hdr_idx     <= '0;
                            session     <= hdr_full[159:80];
                            pkt_seq     <= hdr_seq;
                            pkt_msg_cnt <= hdr_cnt;
                            hdr_valid   <= 1'b1;
                            seq_gap     <= SEQ_CHECK_EN & exp_valid & (hdr_seq != exp_seq);
                            // End of session counts as 0 messages and ends tracking.
                            if (hdr_cnt == 16'hFFFF) begin
                                exp_valid <= 1'b0;
                            end else begin
                                exp_valid <= 1'b1;
                                exp_seq   <= hdr_seq + {48'd0, hdr_cnt};
                            end
                            if ((hdr_cnt == 16'h0000) || (hdr_cnt == 16'hFFFF)) begin
                                heartbeat   <= (hdr_cnt == 16'h0000);
                                end_session <= (hdr_cnt == 16'hFFFF);
                                if (!s_tlast) begin
                                    err_extra <= 1'b1;
                                    state     <= ST_DRAIN;
                                end
                            end else begin
                                msgs_rem  <= hdr_cnt;
                                m_msg_seq <= hdr_seq;
                                len_phase <= 1'b0;
                                if (s_tlast) begin
                                    err_trunc <= 1'b1;
                                end else begin
                                    state <= ST_LEN;
                                end
                            end
                        end
                    end
                    ST_LEN: begin
                        if (!len_phase) begin
                            len_hi <= s_tdata;
                            if (s_tlast) begin
                                err_trunc <= 1'b1;
                                state     <= ST_HDR;
                            end else begin
                                len_phase <= 1'b1;
                            end
                        end else begin
                            len_phase <= 1'b0;
                            m_msg_len <= len_full;
                            if (len_too_big) begin
                                err_len <= 1'b1;
                                state   <= s_tlast ? ST_HDR : ST_DRAIN;
                            end else if (len_full == 16'd0) begin
                                // Empty message: consumes a sequence number, no beat.
                                msgs_rem  <= msgs_rem - 16'd1;
                                m_msg_seq <= m_msg_seq + 64'd1;
                                if (msgs_rem != 16'd1) begin
                                    if (s_tlast) begin
                                        err_trunc <= 1'b1;
                                        state     <= ST_HDR;
                                    end
                                end else if (s_tlast) begin
                                    state <= ST_HDR;
                                end else begin
                                    err_extra <= 1'b1;
                                    state     <= ST_DRAIN;
                                end
                            end else begin
                                bytes_rem <= len_full;
                                if (s_tlast) begin
                                    err_trunc <= 1'b1;
                                    state     <= ST_HDR;
                                end else begin
                                    state <= ST_DATA;
                                end
                            end
                        end
                    end
                    ST_DATA: begin
                        bytes_rem <= bytes_rem - 16'd1;
                        if (bytes_rem == 16'd1) begin
                            msgs_rem  <= msgs_rem - 16'd1;
                            m_msg_seq <= m_msg_seq + 64'd1;
                            if (msgs_rem != 16'd1) begin
                                if (s_tlast) begin
                                    err_trunc <= 1'b1;
                                    state     <= ST_HDR;
                                end else begin
                                    state <= ST_LEN;
                                end
                            end else if (s_tlast) begin
                                state <= ST_HDR;
                            end else begin
                                err_extra <= 1'b1;
                                state     <= ST_DRAIN;
                            end
                        end else if (s_tlast) begin
                            // Byte already went out with m_tlast forced high.
                            err_trunc <= 1'b1;
                            state     <= ST_HDR;
                        end
                    end
                    default: begin
                        if (s_tlast) begin
                            state <= ST_HDR;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_moldudp64_msg_parser.sv
// tb_moldudp64_msg_parser
// Self-checking bench: directed packets plus randomized packets are scored
// against a packet-level reference model that walks each payload as an array.
module tb_moldudp64_msg_parser;

    localparam int MAX = 1024;

    logic         clk;
    logic         rst_n;
    logic [7:0]   s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic [7:0]   m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tfirst;
    logic         m_tlast;
    logic [63:0]  m_msg_seq;
    logic [15:0]  m_msg_len;
    logic [79:0]  session;
    logic [63:0]  pkt_seq;
    logic [15:0]  pkt_msg_cnt;
    logic         hdr_valid, heartbeat, end_session, seq_gap;
    logic         err_len, err_trunc, err_extra;

    moldudp64_msg_parser #(.MAX_MSG_LEN(MAX), .SEQ_CHECK_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tfirst(m_tfirst), .m_tlast(m_tlast),
        .m_msg_seq(m_msg_seq), .m_msg_len(m_msg_len),
        .session(session), .pkt_seq(pkt_seq), .pkt_msg_cnt(pkt_msg_cnt),
        .hdr_valid(hdr_valid), .heartbeat(heartbeat), .end_session(end_session),
        .seq_gap(seq_gap), .err_len(err_len), .err_trunc(err_trunc), .err_extra(err_extra)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // expected beat: {data, first, last, msg_seq, msg_len}
    logic [89:0] exp_q[$];
    int e_hdr, e_hb, e_end, e_gap, e_len, e_trunc, e_extra;
    int o_hdr, o_hb, o_end, o_gap, o_len, o_trunc, o_extra;
    logic [79:0] e_session;
    logic [63:0] e_pkt_seq;
    logic [15:0] e_cnt;
    logic [63:0] m_exp_seq;
    logic        m_exp_v;
    logic        mon_en;
    int          rdy_mode;
    logic [7:0]  pkt[$];

    // Monitor: pulse counting and beat scoring away from the active edge.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (hdr_valid)   o_hdr++;
            if (heartbeat)   o_hb++;
            if (end_session) o_end++;
            if (seq_gap)     o_gap++;
            if (err_len)     o_len++;
            if (err_trunc)   o_trunc++;
            if (err_extra)   o_extra++;
            if (m_tvalid) check("rdy_follow", 96'(s_tready), 96'(m_tready));
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0)
                    check("beat_unexpected", 96'({m_tdata, m_tfirst, m_tlast, m_msg_seq, m_msg_len}), 96'('1));
                else
                    check("beat", 96'({m_tdata, m_tfirst, m_tlast, m_msg_seq, m_msg_len}), 96'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: m_tready = 1'($urandom_range(1));
                2: m_tready = ~m_tready;
                default: m_tready = 1'b1;
            endcase
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference model: walks a whole packet by byte position.
    task automatic model_pkt();
        int n;
        int pos;
        logic [79:0] ses;
        logic [63:0] seq, sq;
        logic [15:0] cnt, l;
        n = pkt.size();
        if (n < 20) begin
            e_trunc++;
            return;
        end
        ses = '0;
        seq = '0;
        for (int i = 0; i < 10; i++) ses = {ses[71:0], pkt[i]};
        for (int i = 10; i < 18; i++) seq = {seq[55:0], pkt[i]};
        cnt = {pkt[18], pkt[19]};
        e_hdr++;
        e_session = ses;
        e_pkt_seq = seq;
        e_cnt = cnt;
        if (m_exp_v && seq != m_exp_seq) e_gap++;
        if (cnt == 16'hFFFF) m_exp_v = 1'b0;
        else begin
            m_exp_v = 1'b1;
            m_exp_seq = seq + 64'(cnt);
        end
        if (cnt == 16'h0000 || cnt == 16'hFFFF) begin
            if (cnt == 16'h0000) e_hb++;
            else e_end++;
            if (n > 20) e_extra++;
            return;
        end
        pos = 20;
        sq = seq;
        for (int m = 0; m < int'(cnt); m++) begin
            if (pos + 2 > n) begin
                e_trunc++;
                return;
            end
            l = {pkt[pos], pkt[pos+1]};
            pos += 2;
            if (int'(l) > MAX) begin
                e_len++;
                return;
            end
            for (int j = 0; j < int'(l); j++) begin
                exp_q.push_back({pkt[pos], 1'(j == 0), 1'((j == int'(l) - 1) || (pos == n - 1)), sq, l});
                pos++;
                if (pos == n && j != int'(l) - 1) begin
                    e_trunc++;
                    return;
                end
            end
            sq++;
            if (m == int'(cnt) - 1) begin
                if (pos < n) e_extra++;
            end else if (pos == n) begin
                e_trunc++;
                return;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
        int t;
        t = 0;
        if (gap != 0 && $urandom_range(3) == 0) begin
            s_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            t++;
            if (t > 200) begin
                check("tready_timeout", 96'(t), 96'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int gap);
        for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], 1'(i == pkt.size() - 1), gap);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ":hdr_valid"},   96'(o_hdr),   96'(e_hdr));
        check({tag, ":heartbeat"},   96'(o_hb),    96'(e_hb));
        check({tag, ":end_session"}, 96'(o_end),   96'(e_end));
        check({tag, ":seq_gap"},     96'(o_gap),   96'(e_gap));
        check({tag, ":err_len"},     96'(o_len),   96'(e_len));
        check({tag, ":err_trunc"},   96'(o_trunc), 96'(e_trunc));
        check({tag, ":err_extra"},   96'(o_extra), 96'(e_extra));
        check({tag, ":beats_left"},  96'(exp_q.size()), 96'd0);
        check({tag, ":session"},     96'(session),     96'(e_session));
        check({tag, ":pkt_seq"},     96'(pkt_seq),     96'(e_pkt_seq));
        check({tag, ":pkt_msg_cnt"}, 96'(pkt_msg_cnt), 96'(e_cnt));
        exp_q.delete();
    endtask

    task automatic run_pkt(input string tag, input int gap);
        model_pkt();
        send_pkt(gap);
        compare_all(tag);
    endtask

    task automatic push16(input logic [15:0] v);
        pkt.push_back(v[15:8]);
        pkt.push_back(v[7:0]);
    endtask

    task automatic push_hdr(input logic [79:0] ses, input logic [63:0] seq, input logic [15:0] cnt);
        pkt.delete();
        for (int i = 9; i >= 0; i--) pkt.push_back(ses[i*8 +: 8]);
        for (int i = 7; i >= 0; i--) pkt.push_back(seq[i*8 +: 8]);
        push16(cnt);
    endtask

    task automatic push_msg(input logic [15:0] len, input int nbytes);
        push16(len);
        for (int i = 0; i < nbytes; i++) pkt.push_back(8'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":outs"}, 96'({s_tready, m_tvalid, m_tdata, m_tfirst, m_tlast, hdr_valid, heartbeat,
                                   end_session, seq_gap, err_len, err_trunc, err_extra}), 96'd0);
        check({tag, ":msg_seq"}, 96'(m_msg_seq), 96'd0);
        check({tag, ":msg_len"}, 96'(m_msg_len), 96'd0);
        check({tag, ":session"}, 96'(session), 96'd0);
        check({tag, ":pkt_seq"}, 96'(pkt_seq), 96'd0);
        check({tag, ":cnt"},     96'(pkt_msg_cnt), 96'd0);
    endtask

    initial begin
        logic [79:0] ses;
        logic [63:0] seq;
        logic [15:0] cnt, len;
        int r;
        rst_n = 1'b0;
        s_tdata = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        rdy_mode = 0;
        mon_en = 1'b1;
        m_exp_v = 1'b0;
        m_exp_seq = '0;
        e_session = '0;
        e_pkt_seq = '0;
        e_cnt = '0;
        {e_hdr, e_hb, e_end, e_gap, e_len, e_trunc, e_extra} = '0;
        {o_hdr, o_hb, o_end, o_gap, o_len, o_trunc, o_extra} = '0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Valid packet, then heartbeat with a sequence gap.
        ses = "TESTSESS01";
        push_hdr(ses, 64'd100, 16'd2);
        push_msg(16'd3, 3);
        push_msg(16'd1, 1);
        run_pkt("valid", 0);
        push_hdr(ses, 64'd103, 16'd0);
        run_pkt("heartbeat", 0);

        // Backpressure toggling during a 5-byte message.
        rdy_mode = 2;
        push_hdr(ses, 64'd103, 16'd1);
        push_msg(16'd5, 5);
        run_pkt("backpressure", 0);
        rdy_mode = 0;

        // Over-long length, drained, then a normal packet.
        push_hdr(ses, 64'd104, 16'd2);
        push_msg(16'd2000, 4);
        run_pkt("err_len", 0);
        push_hdr(ses, 64'd106, 16'd1);
        push_msg(16'd2, 2);
        run_pkt("after_len", 0);

        // Truncation on byte 2 of a 6-byte message.
        push_hdr(ses, 64'd107, 16'd1);
        push_msg(16'd6, 2);
        run_pkt("trunc", 0);

        // Boundary lengths: MAX accepted, zero-length message, end of session.
        push_hdr(ses, 64'd108, 16'd3);
        push_msg(16'd0, 0);
        push_msg(16'(MAX), MAX);
        push_msg(16'd1, 1);
        run_pkt("len_bounds", 0);
        push_hdr(ses, 64'd111, 16'hFFFF);
        pkt.push_back(8'hAA);
        run_pkt("end_session", 0);

        // Randomized packets with random valid gaps and random backpressure.
        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            ses = {$urandom, $urandom, 16'($urandom)};
            seq = (m_exp_v && $urandom_range(4) != 0) ? m_exp_seq : {$urandom, $urandom};
            r = $urandom_range(9);
            cnt = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom_range(4, 1));
            push_hdr(ses, seq, cnt);
            if (cnt != 16'h0000 && cnt != 16'hFFFF) begin
                for (int m = 0; m < int'(cnt); m++) begin
                    if ($urandom_range(14) == 0) begin
                        push_msg(16'd1500, 3);
                        break;
                    end
                    len = 16'($urandom_range(6));
                    push_msg(len, int'(len));
                end
            end
            r = $urandom_range(9);
            if (r == 0) begin
                for (int i = 0; i <= int'($urandom_range(2)); i++) pkt.push_back(8'($urandom));
            end else if (r == 1 && pkt.size() > 1) begin
                r = $urandom_range(pkt.size() - 1, 1);
                while (pkt.size() > r) void'(pkt.pop_back());
            end
            run_pkt($sformatf("rand%0d", k), 1);
        end
        rdy_mode = 0;

        // Reset mid-DATA: partial packet is lost, next packet parses cleanly.
        mon_en = 1'b0;
        push_hdr(ses, 64'd5000, 16'd1);
        push_msg(16'd6, 6);
        for (int i = 0; i < 24; i++) send_byte(pkt[i], 1'b0, 0);
        s_tvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        exp_q.delete();
        m_exp_v = 1'b0;
        e_session = '0;
        e_pkt_seq = '0;
        e_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        push_hdr("AFTERRESET", 64'd9000, 16'd2);
        push_msg(16'd2, 2);
        push_msg(16'd3, 3);
        run_pkt("post_reset", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
